// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg
//   Shared definitions for the Cache port arbiter: FSM state encoding,
//   requester port indices and the timeout counter width.
package cache_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

    // Wide enough for TIMEOUT_CYCLES up to 255.
    localparam int unsigned TO_CNT_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin pick with its last-grant register.
//   Ports:
//     clk, rst_n     clock, async active-low reset
//     i_req0/i_req1  request lines
//     i_take         grant accepted this cycle; records o_gnt as last grant
//     o_valid        at least one request present
//     o_gnt          granted port index (valid while o_valid)
module rr_arbiter2
    import cache_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_valid,
    output logic o_gnt
);

    logic r_last;

    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_gnt = ~r_last;
        end else if (i_req1) begin
            o_gnt = PORT_LSU;
        end else begin
            o_gnt = PORT_IFETCH;
        end
    end

    // Resets to the LSU port so instruction fetch wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_LSU;
        end else if (i_take && o_valid) begin
            r_last <= o_gnt;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares the single Cache port between instruction fetch (port 0) and
//   load/store (port 1), one transaction at a time, round-robin on ties.
//   A transaction walks IDLE -> ISSUE -> WAIT -> RESP; WAIT ends on
//   cache_data_out_valid or after TIMEOUT_CYCLES cycles with an error.
//   Ports:
//     req/we/addr/wdata 0,1   requester inputs, held until ack
//     ack/rdata/err 0,1       one-cycle completion, rdata/err valid with ack
//     cache_*                 Cache interface (word-aligned address)
//     busy                    high whenever not IDLE
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] cache_address,
    output logic [DATA_W-1:0] cache_data_in,
    output logic              cache_write_enable,
    input  logic [DATA_W-1:0] cache_data_out,
    input  logic              cache_data_out_valid,
    output logic              busy
);

    localparam logic [TO_CNT_W-1:0] TO_LAST   = TO_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0]   ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_take;
    logic                w_gnt_valid;
    logic                w_gnt;
    logic                w_to_hit;
    logic                w_resp;

    logic                r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [TO_CNT_W-1:0] r_cnt;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req0  (req0),
        .i_req1  (req1),
        .i_take  (w_take),
        .o_valid (w_gnt_valid),
        .o_gnt   (w_gnt)
    );

    assign w_to_hit = (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (cache_data_out_valid || w_to_hit) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Transaction latches, response capture and timeout counter. The latched
    // request fields stay put after RESP, which keeps cache_address stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= PORT_IFETCH;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_gnt <= w_gnt;
                        if (w_gnt == PORT_LSU) begin
                            r_addr  <= addr1 & ADDR_MASK;
                            r_we    <= we1;
                            r_wdata <= wdata1;
                        end else begin
                            r_addr  <= addr0 & ADDR_MASK;
                            r_we    <= we0;
                            r_wdata <= wdata0;
                        end
                    end
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    if (cache_data_out_valid) begin
                        r_rdata <= cache_data_out;
                        r_err   <= 1'b0;
                    end else if (w_to_hit) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TO_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_resp             = (r_state == RESP);
    assign ack0               = w_resp && (r_gnt == PORT_IFETCH);
    assign ack1               = w_resp && (r_gnt == PORT_LSU);
    assign rdata0             = ack0 ? r_rdata : '0;
    assign rdata1             = ack1 ? r_rdata : '0;
    assign err0               = ack0 & r_err;
    assign err1               = ack1 & r_err;
    assign busy               = (r_state != IDLE);
    assign cache_address      = r_addr;
    assign cache_data_in      = r_wdata;
    assign cache_write_enable = (r_state == ISSUE) & r_we;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
//   Scoreboard bench: stimulus pushes expected acks and expected Cache
//   writes into queues; a negedge monitor pops and compares whenever the
//   arbiter presents an ack or a write strobe. The Cache is modelled as a
//   small word memory with a controllable data_out_valid.
module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] cache_address, cache_data_in, cache_data_out;
    logic        cache_write_enable, cache_data_out_valid, busy;

    logic        valid_en = 1'b1;
    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wexp_t;

    exp_t  exp_q[$];
    wexp_t wr_q[$];
    exp_t  mon_e;
    wexp_t mon_w;

    cache_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req0                 (req0),
        .req1                 (req1),
        .we0                  (we0),
        .we1                  (we1),
        .addr0                (addr0),
        .addr1                (addr1),
        .wdata0               (wdata0),
        .wdata1               (wdata1),
        .ack0                 (ack0),
        .ack1                 (ack1),
        .rdata0               (rdata0),
        .rdata1               (rdata1),
        .err0                 (err0),
        .err1                 (err1),
        .cache_address        (cache_address),
        .cache_data_in        (cache_data_in),
        .cache_write_enable   (cache_write_enable),
        .cache_data_out       (cache_data_out),
        .cache_data_out_valid (cache_data_out_valid),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: combinational read of the addressed word, writes commit
    // on the clock edge while write_enable is high.
    assign cache_data_out       = mem[cache_address[7:2]];
    assign cache_data_out_valid = valid_en;

    always @(posedge clk) begin
        if (cache_write_enable) mem[cache_address[7:2]] <= cache_data_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic port, input logic [31:0] rd, input logic e,
                            input logic [31:0] a, input int c);
        exp_t x;
        x.port = port; x.rdata = rd; x.err = e; x.addr = a; x.cyc = c;
        exp_q.push_back(x);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wexp_t w;
        w.addr = a; w.data = d;
        wr_q.push_back(w);
    endtask

    // Monitor: compares every ack and every write strobe against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cache_write_enable) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write_unexpected: write strobe addr %h data %h, none expected",
                             cache_address, cache_data_in);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", cache_address, mon_w.addr);
                    check("wr_data", cache_data_in, mon_w.data);
                end
            end
            if (ack0 || ack1) begin
                check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
                check("busy_in_resp", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected: ack0=%b ack1=%b, none expected", ack0, ack1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_port", 32'(ack1), 32'(mon_e.port));
                    check("rdata", ack1 ? rdata1 : rdata0, mon_e.rdata);
                    check("err", 32'(ack1 ? err1 : err0), 32'(mon_e.err));
                    check("resp_addr", cache_address, mon_e.addr);
                    check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    task automatic raise(input logic port, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
        end else begin
            we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
        end
    endtask

    // Waits (bounded) for the port's ack, then drops req in the next cycle.
    task automatic wait_drop(input logic port, input int max_cycles);
        bit got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if ((port && ack1) || (!port && ack0)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: port %0d no ack within %0d cycles", port, max_cycles);
        end
        @(posedge clk); #1;
        if (port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic drive_port(input logic port, input logic w, input logic [31:0] base_a,
                              input logic [31:0] base_d);
        for (int k = 0; k < 3; k++) begin
            raise(port, w, base_a + 32'(4 * k), base_d + 32'(k));
            wait_drop(port, 40);
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack0"}, 32'(ack0), 32'd0);
        check({tag, "_ack1"}, 32'(ack1), 32'd0);
        check({tag, "_err0"}, 32'(err0), 32'd0);
        check({tag, "_err1"}, 32'(err1), 32'd0);
        check({tag, "_rdata0"}, rdata0, 32'd0);
        check({tag, "_rdata1"}, rdata1, 32'd0);
        check({tag, "_cache_address"}, cache_address, 32'd0);
        check({tag, "_cache_data_in"}, cache_data_in, 32'd0);
        check({tag, "_cache_we"}, 32'(cache_write_enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        for (int i = 0; i < 64; i++) mem[i] = 32'h5500_0000 + 32'(i);
        mem[4]  = 32'h1234_5678;                  // 0x10
        for (int k = 0; k < 3; k++) mem[8 + k] = 32'hA000_0020 + 32'(4 * k);  // 0x20..0x28
        mem[16] = 32'hCAFE_F00D;                  // 0x40
        mem[17] = 32'h4444_4444;                  // 0x44

        // Reset state
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;

        // Single read, port 0
        @(posedge clk); #1;
        push_exp(1'b0, 32'h1234_5678, 1'b0, 32'h0000_0010, cyc + 3);
        raise(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        wait_drop(1'b0, 20);

        // Address masking, port 0
        @(posedge clk); #1;
        push_exp(1'b0, 32'h1234_5678, 1'b0, 32'h0000_0010, cyc + 3);
        raise(1'b0, 1'b0, 32'h0000_0013, 32'h0);
        wait_drop(1'b0, 20);

        // Single write, port 1 (leaves last_grant = 1)
        @(posedge clk); #1;
        push_wr(32'h0000_0004, 32'hDEAD_BEEF);
        push_exp(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0004, cyc + 3);
        raise(1'b1, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
        wait_drop(1'b1, 20);

        // Contention: port 0 reads 0x20.., port 1 writes 0x30..; grants 0,1,0,1,0,1
        @(posedge clk); #1;
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            push_exp(1'b0, 32'hA000_0020 + 32'(4 * k), 1'b0, 32'h20 + 32'(4 * k), c + 3 + 8 * k);
            push_exp(1'b1, 32'hB000_0000 + 32'(k), 1'b0, 32'h30 + 32'(4 * k), c + 7 + 8 * k);
            push_wr(32'h30 + 32'(4 * k), 32'hB000_0000 + 32'(k));
        end
        fork
            drive_port(1'b0, 1'b0, 32'h20, 32'h0);
            drive_port(1'b1, 1'b1, 32'h30, 32'hB000_0000);
        join

        // Timeout: valid never arrives, ack0 10 cycles after the grant cycle
        @(posedge clk); #1;
        valid_en = 1'b0;
        push_exp(1'b0, 32'h0, 1'b1, 32'h0000_0040, cyc + 10);
        raise(1'b0, 1'b0, 32'h0000_0040, 32'h0);
        wait_drop(1'b0, 30);
        valid_en = 1'b1;

        // Next request after timeout is served normally
        @(posedge clk); #1;
        push_exp(1'b1, 32'hB000_0001, 1'b0, 32'h0000_0034, cyc + 3);
        raise(1'b1, 1'b0, 32'h0000_0034, 32'h0);
        wait_drop(1'b1, 20);

        // Reset during WAIT: aborted with no ack, then the pending req1 wins
        @(posedge clk); #1;
        valid_en = 1'b0;
        raise(1'b0, 1'b0, 32'h0000_0044, 32'h0);
        repeat (3) @(posedge clk);
        #3;
        check("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        raise(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        #1;
        check_all_zero("midreset");
        req0 = 1'b0;
        valid_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_exp(1'b1, 32'h4444_4444, 1'b0, 32'h0000_0044, cyc + 3);
        wait_drop(1'b1, 20);

        repeat (5) @(posedge clk);
        #1;
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("write_queue_empty", 32'(wr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
